bus_arbiter: RTL and testbench

Registered 32-source round-robin arbiter that drives the 5-bit `select` input of the datapath bus multiplexer. Each of the 32 register sources raises a request line; the arbiter grants one source at a time, holds the grant for at most `MAX_HOLD` cycles unless locked, and publishes the winner as a binary index plus a one-hot grant. It sits directly upstream of the bus multiplexer and replaces the control unit's direct drive of `select`.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_arbiter_if.sv | 29 ++
 rtl/bus_arbiter_rr_pick.sv | 37 +++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 129 ++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus: source count, select width,
// arbiter state encoding and a small one-hot helper. The bus multiplexer
// and control unit import this package as well.
package bus_pkg;

  // Number of register sources on the datapath bus (fixed for this datapath).
  localparam int N_SRC = 32;
  // Width of the multiplexer select; equals clog2(N_SRC).
  localparam int SEL_W = 5;

  // Legacy-compatible raw encodings, kept so older blocks that compare
  // against plain constants still line up with the enum below.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } arb_state_t;

  // One-hot vector with bit `i` set.
  function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] i);
    return N_SRC'(1) << i;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the register sources and the bus arbiter.
// master: the arbiter side, which drives select/grant.
// slave:  the requester side, which drives req/lock.
interface bus_arbiter_if;
  import bus_pkg::*;

  logic [N_SRC-1:0] req;
  logic             lock;
  logic [SEL_W-1:0] select;
  logic [N_SRC-1:0] grant;
  logic             grant_valid;

  modport master (
    input  req,
    input  lock,
    output select,
    output grant,
    output grant_valid
  );

  modport slave (
    output req,
    output lock,
    input  select,
    input  grant,
    input  grant_valid
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin pick: finds the first set request at or above `start`,
// wrapping past the top index back to 0. The request vector is doubled;
// the lower copy has everything below `start` masked off, so the lowest
// set bit of the doubled vector is the round-robin winner.
module rr_pick
  import bus_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [N_SRC-1:0]   keep_mask;
  logic [2*N_SRC-1:0] dbl_req;

  // Bit gi of the lower copy survives only if gi is at or above start.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_mask
      assign keep_mask[gi] = (SEL_W'(gi) >= start);
    end
  endgenerate

  assign dbl_req = {req, req & keep_mask};

  // Lowest set bit of the doubled vector wins; its position mod N_SRC is the index.
  always_comb begin
    idx   = '0;
    found = |req;
    for (int i = 2*N_SRC-1; i >= 0; i--) begin
      if (dbl_req[i]) begin
        idx = i[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Registered round-robin bus arbiter driving the bus multiplexer select.
// Grants one source at a time, rotates after MAX_HOLD cycles when others
// are waiting (unless locked), and hands over without an idle bubble when
// the owner drops its request. All outputs come straight from registers.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 8  // legal range 2..255
) (
  input  logic          clk,
  input  logic          clr,
  bus_arbiter_if.master bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t       state_reg,  state_next;
  logic [SEL_W-1:0] ptr_reg,    ptr_next;
  logic [7:0]       hcnt_reg,   hcnt_next;
  logic [SEL_W-1:0] select_reg, select_next;
  logic [N_SRC-1:0] grant_reg,  grant_next;
  logic             valid_reg,  valid_next;

  logic             owner_req;
  logic             others_req;
  logic             at_limit;
  logic             rotating;
  logic [SEL_W-1:0] pick_start;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic [7:0]       hcnt_sat;

  // grant_reg is one-hot on the owner while in GRANT, so masking with it
  // splits the request vector into "owner" and "everybody else".
  assign owner_req  = |(bus.req & grant_reg);
  assign others_req = |(bus.req & ~grant_reg);
  assign at_limit   = (hcnt_reg == HOLD_LAST);
  assign hcnt_sat   = at_limit ? hcnt_reg : hcnt_reg + 8'd1;

  // A forced rotation searches from just past the owner; otherwise the
  // rotation pointer is the starting point.
  assign rotating   = (state_reg == GRANT) && owner_req && !bus.lock && at_limit;
  assign pick_start = rotating ? select_reg + 1'b1 : ptr_reg;

  rr_pick u_pick (
    .req   (bus.req),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state decision: idle acquisition, handover, release, lock, rotation.
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    hcnt_next   = hcnt_reg;
    select_next = select_reg;
    grant_next  = grant_reg;
    valid_next  = valid_reg;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next  = GRANT;
          select_next = pick_idx;
          grant_next  = onehot(pick_idx);
          valid_next  = 1'b1;
          ptr_next    = pick_idx + 1'b1;
          hcnt_next   = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (others_req) begin
            // Owner let go while others wait: hand over with no bubble.
            select_next = pick_idx;
            grant_next  = onehot(pick_idx);
            ptr_next    = pick_idx + 1'b1;
            hcnt_next   = '0;
          end else begin
            // Nobody wants the bus; select keeps the last owner.
            state_next = IDLE;
            grant_next = '0;
            valid_next = 1'b0;
          end
        end else if (bus.lock) begin
          hcnt_next = hcnt_sat;
        end else if (at_limit && others_req) begin
          select_next = pick_idx;
          grant_next  = onehot(pick_idx);
          ptr_next    = pick_idx + 1'b1;
          hcnt_next   = '0;
        end else begin
          hcnt_next = hcnt_sat;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers; clr clears everything without waiting for clk.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      hcnt_reg   <= '0;
      select_reg <= '0;
      grant_reg  <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      hcnt_reg   <= hcnt_next;
      select_reg <= select_next;
      grant_reg  <= grant_next;
      valid_reg  <= valid_next;
    end
  end

  assign bus.select      = select_reg;
  assign bus.grant       = grant_reg;
  assign bus.grant_valid = valid_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter (MAX_HOLD = 4).
module tb_bus_arbiter;
  import bus_pkg::*;

  typedef struct {
    logic [31:0] req;
    logic        lock;
    logic [4:0]  sel;
    logic        valid;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  bus_arbiter_if bif();

  bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bif)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected grant is derived from the expected owner and valid flag.
  task automatic check(input string name, input logic [4:0] sel, input logic valid);
    logic [31:0] g;
    g = valid ? (32'd1 << sel) : 32'd0;
    checks++;
    if (bif.select !== sel || bif.grant !== g || bif.grant_valid !== valid) begin
      errors++;
      $display("FAIL %s: got sel=%0d grant=%h valid=%b, want sel=%0d grant=%h valid=%b",
               name, bif.select, bif.grant, bif.grant_valid, sel, g, valid);
    end else begin
      $display("ok   %s: req=%h lock=%b sel=%0d grant=%h valid=%b",
               name, bif.req, bif.lock, bif.select, bif.grant, bif.grant_valid);
    end
  endtask

  function automatic void add(input logic [31:0] req, input logic lock,
                              input logic [4:0] sel, input logic valid, input string name);
    vec_t v;
    v.req = req; v.lock = lock; v.sel = sel; v.valid = valid; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    // ---- vector table (starts from a freshly cleared arbiter, ptr = 0) ----
    // single request for 3 cycles, then dropped
    add(32'h0000_0020, 1'b0, 5'd5, 1'b1, "single_first");
    add(32'h0000_0020, 1'b0, 5'd5, 1'b1, "single_hold1");
    add(32'h0000_0020, 1'b0, 5'd5, 1'b1, "single_hold2");
    add(32'h0000_0000, 1'b0, 5'd5, 1'b0, "single_drop");
    add(32'h0000_0000, 1'b0, 5'd5, 1'b0, "idle_keeps_sel");
    // fair rotation between 3 and 30 (ptr = 6, so 30 wins first)
    for (int k = 0; k < 12; k++) begin
      add(32'h4000_0008, 1'b0, ((k / 4) % 2 == 1) ? 5'd3 : 5'd30, 1'b1, "rotate");
    end
    // wrap-around 31 -> 0 -> 2
    add(32'h8000_0000, 1'b0, 5'd31, 1'b1, "handover_31");
    add(32'h8000_0005, 1'b0, 5'd31, 1'b1, "hold_31");
    add(32'h0000_0005, 1'b0, 5'd0,  1'b1, "wrap_to_0");
    add(32'h0000_0005, 1'b0, 5'd0,  1'b1, "hold_0");
    add(32'h0000_0004, 1'b0, 5'd2,  1'b1, "then_2");
    add(32'h0000_0000, 1'b0, 5'd2,  1'b0, "idle_after_2");
    // lock: owner 7 keeps bus for 20 cycles while 9 waits
    add(32'h0000_0080, 1'b0, 5'd7, 1'b1, "grant_7");
    for (int k = 0; k < 20; k++) begin
      add(32'h0000_0280, 1'b1, 5'd7, 1'b1, "locked_7");
    end
    add(32'h0000_0280, 1'b0, 5'd9, 1'b1, "unlock_to_9");
    add(32'h0000_0080, 1'b1, 5'd7, 1'b1, "lock_no_retain");
    add(32'h0000_0000, 1'b1, 5'd7, 1'b0, "lock_drop_idle");
    add(32'h0000_0000, 1'b1, 5'd7, 1'b0, "idle_lock_stay");
    add(32'h0000_0002, 1'b1, 5'd1, 1'b1, "idle_ignores_lock");
    add(32'h0000_0000, 1'b0, 5'd1, 1'b0, "final_idle");

    // ---- hand-written sequence: async reset behaviour ----
    clr      = 1'b0;
    bif.req  = '1;
    bif.lock = 1'b0;
    #2 clr = 1'b1;
    #1 check("reset_async", 5'd0, 1'b0);
    step;
    check("reset_held", 5'd0, 1'b0);
    clr = 1'b0;
    step;
    check("first_after_reset", 5'd0, 1'b1);
    bif.req = 32'h0000_0080;
    step;
    check("handover_to_7", 5'd7, 1'b1);
    // clear between edges while grant = 0x80
    #2 clr = 1'b1;
    #1 check("async_mid_grant", 5'd0, 1'b0);
    step;
    check("clr_held", 5'd0, 1'b0);
    clr     = 1'b0;
    bif.req = 32'h0000_0081;
    step;
    check("restart_from_0", 5'd0, 1'b1);
    bif.req = '0;
    step;
    check("drop_to_idle", 5'd0, 1'b0);
    clr = 1'b1;
    step;
    clr = 1'b0;

    // ---- table sweep ----
    foreach (vecs[i]) begin
      bif.req  = vecs[i].req;
      bif.lock = vecs[i].lock;
      step;
      check(vecs[i].name, vecs[i].sel, vecs[i].valid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
